// File: rtl/log_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : log_arbiter_pkg
// Purpose : Shared types and constants for the log-engine arbiter.
//           - INPUTOUTBIT : width of operand/result buses
//           - TO_CNT_W    : watchdog counter width (covers TIMEOUT_CYCLES<=65535)
//           - RESULT_MASK : keeps only the BF16 field of an engine result
//           - state_t     : arbiter FSM states
// Revision: 1.0 - initial release
// ============================================================================
package log_arbiter_pkg;

  localparam int INPUTOUTBIT = 32;
  localparam int TO_CNT_W    = 16;

  // Result bus carries BF16 in [15:0]; upper bits are forced to zero.
  localparam logic [INPUTOUTBIT-1:0] RESULT_MASK = INPUTOUTBIT'(32'h0000_FFFF);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/log_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin priority encoder. Searches req starting
//           at ptr+1 and wrapping; the first set bit wins.
// Ports   : req       - request vector
//           ptr       - index of the most recently granted requester
//           grant     - index of the selected requester (valid when any_valid)
//           any_valid - at least one request bit is set
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant,
  output logic               any_valid
);

  logic [PTR_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit after ptr
  // is the last one assigned and therefore wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (req[idx]) begin
        grant = idx;
      end
    end
  end

  assign any_valid = |req;

endmodule
`default_nettype wire

// File: rtl/log_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : log_arbiter
// Purpose : Shares one iterative log engine among NUM_REQ requesters with
//           round-robin arbitration, engine start/done sequencing, response
//           routing to the owning requester and a watchdog timeout.
// Ports   : clk, rst                       - clock, synchronous active-high reset
//           req_valid/req_ready/req_a/req_b - per-requester request side
//           resp_valid/resp_ready           - per-requester response handshake
//           resp_result/error/timeout       - shared response payload
//           busy                            - FSM not idle
//           eng_*                           - engine handshake and operands
// Revision: 1.0 - initial release
// ============================================================================
module log_arbiter
  import log_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PTR_W          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*INPUTOUTBIT-1:0] req_a,
  input  logic [NUM_REQ*INPUTOUTBIT-1:0] req_b,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [INPUTOUTBIT-1:0]         resp_result,
  output logic                           resp_error,
  output logic                           resp_timeout,
  output logic                           busy,
  output logic                           eng_start,
  output logic [INPUTOUTBIT-1:0]         eng_a,
  output logic [INPUTOUTBIT-1:0]         eng_b,
  input  logic [INPUTOUTBIT-1:0]         eng_result,
  input  logic                           eng_error,
  input  logic                           eng_done,
  output logic                           eng_abort
);

  // Counter value in the last allowed ISSUE cycle; the abort becomes visible
  // TIMEOUT_CYCLES cycles after eng_start rose.
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      owner;
  logic [PTR_W-1:0]      grant;
  logic                  any_valid;
  logic [TO_CNT_W-1:0]   to_cnt;
  logic [INPUTOUTBIT-1:0] a_slice [NUM_REQ];
  logic [INPUTOUTBIT-1:0] b_slice [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign a_slice[k] = req_a[k*INPUTOUTBIT +: INPUTOUTBIT];
    assign b_slice[k] = req_b[k*INPUTOUTBIT +: INPUTOUTBIT];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // The accept pulse is combinational so the grant and the operand capture
  // happen on the same edge; operands only need to be stable this cycle.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && any_valid && !rst) begin
      req_ready = NUM_REQ'(1) << grant;
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= PTR_W'(NUM_REQ - 1);
      owner        <= '0;
      to_cnt       <= '0;
      eng_start    <= 1'b0;
      eng_abort    <= 1'b0;
      eng_a        <= '0;
      eng_b        <= '0;
      resp_valid   <= '0;
      resp_result  <= '0;
      resp_error   <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      eng_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            eng_a     <= a_slice[grant];
            eng_b     <= b_slice[grant];
            owner     <= grant;
            ptr       <= grant;
            to_cnt    <= '0;
            eng_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // done is checked first so it wins over a coincident timeout
          if (eng_done) begin
            eng_start    <= 1'b0;
            // engine leaves its old result on error, so mask it
            resp_result  <= eng_error ? '0 : (eng_result & RESULT_MASK);
            resp_error   <= eng_error;
            resp_timeout <= 1'b0;
            state        <= S_RELEASE;
          end else if (to_cnt == TO_LAST) begin
            eng_start    <= 1'b0;
            eng_abort    <= 1'b1;
            resp_result  <= '0;
            resp_error   <= 1'b1;
            resp_timeout <= 1'b1;
            resp_valid   <= NUM_REQ'(1) << owner;
            state        <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          // hold off until the engine drops done, so a stale done can never
          // be mistaken for completion of the next job
          if (!eng_done) begin
            resp_valid <= NUM_REQ'(1) << owner;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready[owner]) begin
            resp_valid   <= '0;
            resp_result  <= '0;
            resp_error   <= 1'b0;
            resp_timeout <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_log_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_log_arbiter
// Purpose : Self-checking bench for log_arbiter with a behavioural engine stub
//           and an expected-response scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_log_arbiter;
  import log_arbiter_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int PTR_W   = 2;
  localparam int TIMEOUT = 16;
  localparam int DW      = INPUTOUTBIT;
  localparam int ENG_LAT = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*DW-1:0]  req_a = '0;
  logic [NUM_REQ*DW-1:0]  req_b = '0;
  logic [NUM_REQ-1:0]     resp_valid;
  logic [NUM_REQ-1:0]     resp_ready = '0;
  logic [DW-1:0]          resp_result;
  logic                   resp_error, resp_timeout, busy;
  logic                   eng_start, eng_abort;
  logic [DW-1:0]          eng_a, eng_b;
  logic [DW-1:0]          eng_result;
  logic                   eng_error, eng_done;

  always #5 clk = ~clk;

  log_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .PTR_W          (PTR_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_result  (resp_result),
    .resp_error   (resp_error),
    .resp_timeout (resp_timeout),
    .busy         (busy),
    .eng_start    (eng_start),
    .eng_a        (eng_a),
    .eng_b        (eng_b),
    .eng_result   (eng_result),
    .eng_error    (eng_error),
    .eng_done     (eng_done),
    .eng_abort    (eng_abort)
  );

  // ---------------- engine stub ----------------
  typedef enum logic [1:0] {E_IDLE, E_RUN, E_HOLD, E_CLR} eng_st_t;
  eng_st_t e_st;
  int      e_cnt;
  bit      hang = 1'b0;

  function automatic logic [DW-1:0] log_ref(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (a == 2 && b == 8) return 32'h0000_4040;
    if (a == 2 && b == 4) return 32'h0000_4000;
    if (a == 2 && b == 2) return 32'h0000_3F80;
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (rst || eng_abort) begin
      e_st      <= E_IDLE;
      e_cnt     <= 0;
      eng_done  <= 1'b0;
      eng_error <= 1'b0;
      if (rst) eng_result <= '0;
    end else begin
      case (e_st)
        E_IDLE: if (eng_start) begin
          e_st      <= E_RUN;
          e_cnt     <= ENG_LAT;
          eng_error <= 1'b0;
        end
        E_RUN: if (!hang) begin
          if (e_cnt > 1) e_cnt <= e_cnt - 1;
          else begin
            eng_done <= 1'b1;
            e_st     <= E_HOLD;
            if (eng_a == 1 || eng_b == 0) eng_error <= 1'b1;   // result left untouched
            else eng_result <= log_ref(eng_a, eng_b);
          end
        end
        E_HOLD: if (!eng_start) e_st <= E_CLR;
        E_CLR: begin
          eng_done <= 1'b0;
          e_st     <= E_IDLE;
        end
        default: e_st <= E_IDLE;
      endcase
    end
  end

  // ---------------- bookkeeping ----------------
  typedef struct {
    int            owner;
    logic [DW-1:0] result;
    logic          err;
    logic          to;
  } exp_t;

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic [DW-1:0]      result;
    logic               err;
    logic               to;
  } rsp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [NUM_REQ-1:0] s_req_ready = '0, s_resp_valid = '0;
  logic [DW-1:0]      s_result = '0, s_eng_a = '0, s_eng_b = '0;
  logic               s_err = 0, s_to = 0, s_busy = 0, s_start = 0, s_abort = 0;

  // One clock: sample at negedge, retire accepted requests after the posedge.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    cyc++;
    s_req_ready  = req_ready;
    s_resp_valid = resp_valid;
    s_result     = resp_result;
    s_err        = resp_error;
    s_to         = resp_timeout;
    s_busy       = busy;
    s_start      = eng_start;
    s_abort      = eng_abort;
    s_eng_a      = eng_a;
    s_eng_b      = eng_b;
    acc = req_ready & req_valid;
    for (int k = 0; k < NUM_REQ; k++) if (acc[k]) grant_q.push_back(k);
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic set_req(input int k, input int a, input int b);
    req_a[k*DW +: DW] = DW'(a);
    req_b[k*DW +: DW] = DW'(b);
  endtask

  // Waits (bounded) for a response, captures it, then acknowledges it.
  task automatic collect_resp(output rsp_t r, output bit ok);
    ok = 1'b0;
    r  = '{default: '0};
    for (int i = 0; i < 200 && !ok; i++) begin
      if (s_resp_valid != '0) begin
        r.valid  = s_resp_valid;
        r.result = s_result;
        r.err    = s_err;
        r.to     = s_to;
        ok = 1'b1;
      end else begin
        tick();
      end
    end
    if (ok) begin
      resp_ready = s_resp_valid;
      tick();
      resp_ready = '0;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({s_req_ready, s_resp_valid, s_result, s_err, s_to, s_busy, s_start, s_abort, s_eng_a, s_eng_b} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req_ready=%b resp_valid=%b result=%h err=%b to=%b busy=%b start=%b abort=%b, required all 0",
               s_req_ready, s_resp_valid, s_result, s_err, s_to, s_busy, s_start, s_abort);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({s_busy, s_resp_valid, s_start} !== '0) begin
      failures++;
      $display("FAIL reset_release_idle: busy=%b resp_valid=%b start=%b, required 0", s_busy, s_resp_valid, s_start);
    end
  endtask

  task automatic test_single();
    rsp_t r; bit ok; exp_t e; logic [NUM_REQ-1:0] oh;
    set_req(0, 2, 8);
    req_valid = 4'b0001;
    exp_q.push_back(exp_t'{0, 32'h0000_4040, 1'b0, 1'b0});
    tick();
    checks++;
    if (s_req_ready !== 4'b0001) begin
      failures++; $display("FAIL single_accept: req_ready=%b required 0001", s_req_ready);
    end
    set_req(0, 32'hDEAD, 32'hBEEF);   // operands only need to hold on the accept cycle
    tick();
    checks++;
    if ({s_req_ready, s_start, s_busy} !== {4'b0000, 1'b1, 1'b1}) begin
      failures++; $display("FAIL single_pulse_len: req_ready=%b start=%b busy=%b required 0000/1/1", s_req_ready, s_start, s_busy);
    end
    checks++;
    if ({s_eng_a, s_eng_b} !== {32'd2, 32'd8}) begin
      failures++; $display("FAIL single_operands: eng_a=%h eng_b=%h required 2/8", s_eng_a, s_eng_b);
    end
    collect_resp(r, ok);
    e = exp_q.pop_front();
    oh = NUM_REQ'(1) << e.owner;
    checks++;
    if (!ok || {r.valid, r.result, r.err, r.to} !== {oh, e.result, e.err, e.to}) begin
      failures++;
      $display("FAIL single_resp: got ok=%b v=%b r=%h e=%b t=%b required v=%b r=%h e=%b t=%b",
               ok, r.valid, r.result, r.err, r.to, oh, e.result, e.err, e.to);
    end
  endtask

  task automatic test_error();
    rsp_t r; bit ok; exp_t e; logic [NUM_REQ-1:0] oh;
    set_req(1, 1, 5);
    req_valid = 4'b0010;
    exp_q.push_back(exp_t'{1, 32'h0, 1'b1, 1'b0});
    collect_resp(r, ok);
    e = exp_q.pop_front();
    oh = NUM_REQ'(1) << e.owner;
    checks++;
    if (!ok || {r.valid, r.result, r.err, r.to} !== {oh, e.result, e.err, e.to}) begin
      failures++;
      $display("FAIL error_mask: got ok=%b v=%b r=%h e=%b t=%b required v=%b r=%h e=%b t=%b",
               ok, r.valid, r.result, r.err, r.to, oh, e.result, e.err, e.to);
    end
  endtask

  task automatic test_round_robin();
    rsp_t r; bit ok; exp_t e; logic [NUM_REQ-1:0] oh;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int round = 0; round < 2; round++) begin
      grant_q.delete();
      for (int k = 0; k < NUM_REQ; k++) begin
        set_req(k, 2, 4);
        exp_q.push_back(exp_t'{k, 32'h0000_4000, 1'b0, 1'b0});
      end
      req_valid = '1;
      for (int j = 0; j < NUM_REQ; j++) begin
        collect_resp(r, ok);
        e = exp_q.pop_front();
        oh = NUM_REQ'(1) << e.owner;
        checks++;
        if (!ok || {r.valid, r.result, r.err, r.to} !== {oh, e.result, e.err, e.to}) begin
          failures++;
          $display("FAIL rr_resp round%0d job%0d: got ok=%b v=%b r=%h e=%b t=%b required v=%b r=%h",
                   round, j, ok, r.valid, r.result, r.err, r.to, oh, e.result);
        end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        int g;
        g = (grant_q.size() > j) ? grant_q[j] : -1;
        checks++;
        if (g != j) begin
          failures++; $display("FAIL rr_order round%0d slot%0d: granted %0d required %0d", round, j, g, j);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_t r; bit ok; exp_t e; logic [NUM_REQ-1:0] oh;
    logic [DW-1:0] held;
    set_req(0, 2, 8);
    req_valid = 4'b0001;
    exp_q.push_back(exp_t'{0, 32'h0000_4040, 1'b0, 1'b0});
    tick();
    set_req(1, 2, 4);
    req_valid[1] = 1'b1;
    exp_q.push_back(exp_t'{1, 32'h0000_4000, 1'b0, 1'b0});
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = (s_resp_valid != '0);
    end
    e = exp_q.pop_front();
    oh = NUM_REQ'(1) << e.owner;
    checks++;
    if (!ok || {s_resp_valid, s_result, s_err, s_to} !== {oh, e.result, e.err, e.to}) begin
      failures++;
      $display("FAIL bp_first_resp: got ok=%b v=%b r=%h e=%b t=%b required v=%b r=%h", ok, s_resp_valid, s_result, s_err, s_to, oh, e.result);
    end
    held = s_result;
    resp_ready = 4'b1110;   // non-owner acks must be ignored
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({s_resp_valid, s_result, s_err, s_to} !== {4'b0001, held, 1'b0, 1'b0}) begin
        failures++; $display("FAIL bp_hold cyc%0d: v=%b r=%h e=%b t=%b required 0001/%h/0/0", i, s_resp_valid, s_result, s_err, s_to, held);
      end
      checks++;
      if (s_req_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_no_grant cyc%0d: req_ready=%b required 0000", i, s_req_ready);
      end
    end
    resp_ready = 4'b0001;
    tick();
    resp_ready = '0;
    tick();
    checks++;
    if ({s_req_ready, s_resp_valid} !== {4'b0010, 4'b0000}) begin
      failures++; $display("FAIL bp_next_grant: req_ready=%b resp_valid=%b required 0010/0000", s_req_ready, s_resp_valid);
    end
    collect_resp(r, ok);
    e = exp_q.pop_front();
    oh = NUM_REQ'(1) << e.owner;
    checks++;
    if (!ok || {r.valid, r.result, r.err, r.to} !== {oh, e.result, e.err, e.to}) begin
      failures++;
      $display("FAIL bp_second_resp: got ok=%b v=%b r=%h e=%b t=%b required v=%b r=%h", ok, r.valid, r.result, r.err, r.to, oh, e.result);
    end
  endtask

  task automatic test_timeout();
    rsp_t r; bit ok; exp_t e; logic [NUM_REQ-1:0] oh;
    int t_start, t_abort;
    hang = 1'b1;
    set_req(3, 2, 4);
    req_valid = 4'b1000;
    exp_q.push_back(exp_t'{3, 32'h0, 1'b1, 1'b1});
    t_start = -1;
    t_abort = -1;
    for (int i = 0; i < 100 && t_abort < 0; i++) begin
      tick();
      if (s_start && t_start < 0) t_start = cyc;
      if (s_abort) t_abort = cyc;
    end
    checks++;
    if (t_start < 0 || t_abort < 0 || (t_abort - t_start) != TIMEOUT) begin
      failures++; $display("FAIL timeout_latency: start@%0d abort@%0d distance %0d required %0d",
                           t_start, t_abort, t_abort - t_start, TIMEOUT);
    end
    tick();
    checks++;
    if ({s_abort, s_start} !== 2'b00) begin
      failures++; $display("FAIL timeout_abort_pulse: abort=%b start=%b one cycle later, required 0/0", s_abort, s_start);
    end
    hang = 1'b0;
    collect_resp(r, ok);
    e = exp_q.pop_front();
    oh = NUM_REQ'(1) << e.owner;
    checks++;
    if (!ok || {r.valid, r.result, r.err, r.to} !== {oh, e.result, e.err, e.to}) begin
      failures++;
      $display("FAIL timeout_resp: got ok=%b v=%b r=%h e=%b t=%b required v=%b r=%h e=%b t=%b",
               ok, r.valid, r.result, r.err, r.to, oh, e.result, e.err, e.to);
    end
  endtask

  task automatic test_reset_mid();
    rsp_t r; bit ok; exp_t e; logic [NUM_REQ-1:0] oh;
    bit seen;
    set_req(0, 2, 4);
    req_valid = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = s_start;
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL rstmid_issue: eng_start=%b required 1 before reset", s_start);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({s_req_ready, s_resp_valid, s_result, s_err, s_to, s_busy, s_start, s_abort, s_eng_a, s_eng_b} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: req_ready=%b resp_valid=%b result=%h err=%b to=%b busy=%b start=%b abort=%b, required all 0",
               s_req_ready, s_resp_valid, s_result, s_err, s_to, s_busy, s_start, s_abort);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_resp_valid != '0 || s_busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL rstmid_no_resp: response or busy seen after reset, required none");
    end
    set_req(2, 2, 2);
    req_valid = 4'b0100;
    exp_q.push_back(exp_t'{2, 32'h0000_3F80, 1'b0, 1'b0});
    collect_resp(r, ok);
    e = exp_q.pop_front();
    oh = NUM_REQ'(1) << e.owner;
    checks++;
    if (!ok || {r.valid, r.result, r.err, r.to} !== {oh, e.result, e.err, e.to}) begin
      failures++;
      $display("FAIL rstmid_followup: got ok=%b v=%b r=%h e=%b t=%b required v=%b r=%h", ok, r.valid, r.result, r.err, r.to, oh, e.result);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_error();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
